nibble_sum_assembler: RTL and testbench

Receiver-side companion to the nibble adder. It accepts a stream of 5-bit nibble sums, each tagged as low or high nibble, and pairs them with carry propagation into a full 9-bit byte sum. Input and output use valid/ready handshakes. It sits downstream of the nibble adder, which is time-multiplexed through its ctrl select, and reconstructs A+B for 8-bit operands.

---
 rtl/nibble_sum_assembler.sv | 150 +++++++++++++++
 tb/tb_nibble_sum_assembler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_sum_assembler.sv
// nibble_sum_assembler
// Pairs a stream of low/high nibble sums into one 9-bit byte sum.
// A three-state FSM collects the low nibble, then the high nibble, and then
// holds the assembled result until the consumer takes it.
// Optional build macro NIBBLE_ASM_STRICT_EN: checks in_ctrl against the
// expected nibble position and pulses out_err on a mismatch. Without it,
// in_ctrl is ignored and nibbles alternate lo, hi by arrival order.
module nibble_sum_assembler #(
  parameter int NIB_W = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NIB_W:0]     in_q,
  input  logic               in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*NIB_W:0]   out_sum,
  output logic               out_err,
  output logic [CNT_W-1:0]   done_cnt
);

  localparam int SUM_W = 2*NIB_W+1;

  typedef enum logic [1:0] {S_LO, S_HI, S_OUT} state_t;

  state_t             state, state_nxt;
  logic               rdy_en;
  logic               lo_ld, sum_ld, handoff, err_nxt;
  logic [NIB_W:0]     lo_p0;
  logic [SUM_W-1:0]   sum_p1;
  logic               vld_p1;
  logic               err_p1;
  logic [CNT_W-1:0]   cnt;

  // Weights the high nibble sum by 2^NIB_W and adds the low one; the widest
  // possible result (30*16+30) still fits SUM_W bits, so no saturation.
  function automatic logic [SUM_W-1:0] assemble(input logic [NIB_W:0] hi,
                                                input logic [NIB_W:0] lo);
    logic [SUM_W-1:0] hi_x, lo_x;
    hi_x = {{NIB_W{1'b0}}, hi};
    lo_x = {{NIB_W{1'b0}}, lo};
    return (hi_x << NIB_W) + lo_x;
  endfunction

  // Keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LO;
    else        state <= state_nxt;
  end

  // Next-state, handshake and load strobes.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    lo_ld     = 1'b0;
    sum_ld    = 1'b0;
    handoff   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_LO: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) begin
`ifdef NIBBLE_ASM_STRICT_EN
          if (in_ctrl) begin
            err_nxt = 1'b1;
          end else begin
            lo_ld     = 1'b1;
            state_nxt = S_HI;
          end
`else
          // in_ctrl carries no meaning in this build; it never raises an error.
          err_nxt   = in_ctrl & 1'b0;
          lo_ld     = 1'b1;
          state_nxt = S_HI;
`endif
        end
      end
      S_HI: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) begin
`ifdef NIBBLE_ASM_STRICT_EN
          if (!in_ctrl) begin
            lo_ld   = 1'b1;
            err_nxt = 1'b1;
          end else begin
            sum_ld    = 1'b1;
            state_nxt = S_OUT;
          end
`else
          sum_ld    = 1'b1;
          state_nxt = S_OUT;
`endif
        end
      end
      S_OUT: begin
        if (out_ready) begin
          handoff   = 1'b1;
          state_nxt = S_LO;
        end
      end
      default: state_nxt = S_LO;
    endcase
  end

  // Stage p0: capture the low nibble sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lo_p0 <= '0;
    else if (lo_ld) lo_p0 <= in_q;
  end

  // Stage p1: assemble on the high nibble and hold until hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (sum_ld) begin
      sum_p1 <= assemble(in_q, lo_p0);
      vld_p1 <= 1'b1;
    end else if (handoff) begin
      vld_p1 <= 1'b0;
    end
  end

  // Registered one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_p1 <= 1'b0;
    else        err_p1 <= err_nxt;
  end

  // Counts results handed off; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (handoff) cnt <= cnt + 1'b1;
  end

  assign out_valid = vld_p1;
  assign out_sum   = sum_p1;
  assign out_err   = err_p1;
  assign done_cnt  = cnt;

endmodule

// File: tb/tb_nibble_sum_assembler.sv
// Directed bench for nibble_sum_assembler with a queue scoreboard.
module tb_nibble_sum_assembler;
  localparam int NIB_W = 4;
  localparam int CNT_W = 8;
  localparam int SUM_W = 2*NIB_W+1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ctrl = 1'b0;
  logic             out_ready = 1'b0;
  logic [NIB_W:0]   in_q = '0;
  logic             in_ready, out_valid, out_err;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] done_cnt;

  int errs = 0;
  int checks = 0;
  int pops = 0;
  logic [SUM_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_sum_assembler #(.NIB_W(NIB_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_err(out_err), .done_cnt(done_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int q, input bit c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_q     = q[NIB_W:0];
    in_ctrl  = c;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 50) else begin
      errs++;
      $error("FAIL send_timeout: observed=%0d cycles expected=<50", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pair(input int lo, input int hi, input int expv);
    exp_q.push_back(expv[SUM_W-1:0]);
    send(lo, 1'b0);
    send(hi, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: compare each result as it is handed off.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("out_sum", 32'(out_sum), 32'(exp_q.pop_front()));
        pops++;
      end
`ifndef NIBBLE_ASM_STRICT_EN
      chk("out_err_quiet", 32'(out_err), 32'd0);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, p0, lo, hi;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_clk", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_clk", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Basic pair and latency
    out_ready = 1'b1;
    exp_q.push_back(9'h0A5);
    send(5, 1'b0);
    send(10, 1'b1);
    chk("latency_vld", 32'(out_valid), 32'd1);
    chk("latency_sum", 32'(out_sum), 32'h0A5);
    @(posedge clk); #1;
    chk("done_cnt_1", 32'(done_cnt), 32'd1);
    chk("vld_dropped", 32'(out_valid), 32'd0);

    // Pairs checked against the 8-bit A+B they reconstruct
    pair(26, 8, 8'h0d + 8'h8d);
    pair(25, 22, 8'hed + 8'h8c);
    pair(15, 27, 8'hf9 + 8'hc6);
    drain();
    chk("done_cnt_4", 32'(done_cnt), 32'd4);

    // Back-pressure: result held, input blocked
    out_ready = 1'b0;
    exp_q.push_back(9'h0A5);
    send(5, 1'b0);
    send(10, 1'b1);
    in_valid = 1'b1;
    in_q = 5'd7;
    in_ctrl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'h0A5);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("done_cnt_5", 32'(done_cnt), 32'd5);
    chk("hold_single", 32'(out_valid), 32'd0);

    // Asynchronous reset in S_HI discards the stale low nibble
    send(9, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_done_cnt", 32'(done_cnt), 32'd0);
    chk("arst_out_sum", 32'(out_sum), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pair(3, 6, 9'h063);
    drain();
    chk("arst_done_1", 32'(done_cnt), 32'd1);

`ifdef NIBBLE_ASM_STRICT_EN
    // Sequence errors
    send(5, 1'b1);
    chk("err_hi_first", 32'(out_err), 32'd1);
    chk("err_no_out", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("err_one_cycle", 32'(out_err), 32'd0);
    exp_q.push_back(9'h021);
    send(4, 1'b0);
    chk("err_quiet_lo", 32'(out_err), 32'd0);
    send(1, 1'b0);
    chk("err_lo_twice", 32'(out_err), 32'd1);
    send(2, 1'b1);
    chk("strict_vld", 32'(out_valid), 32'd1);
    drain();
    chk("strict_done_2", 32'(done_cnt), 32'd2);
`else
    // in_ctrl ignored: arrival order decides lo/hi
    exp_q.push_back(9'h027);
    send(7, 1'b1);
    chk("noerr_a", 32'(out_err), 32'd0);
    send(2, 1'b1);
    chk("order_vld", 32'(out_valid), 32'd1);
    drain();
    chk("order_done_2", 32'(done_cnt), 32'd2);
`endif

    // Largest result
    pair(30, 30, 510);
    drain();

    // 256 back-to-back pairs wrap the counter
    c0 = int'(done_cnt);
    p0 = pops;
    for (int i = 0; i < 256; i++) begin
      lo = int'($urandom_range(0, 30));
      hi = int'($urandom_range(0, 30));
      pair(lo, hi, hi * 16 + lo);
    end
    drain();
    chk("wrap_done_cnt", 32'(done_cnt), 32'(c0));
    chk("wrap_pops", 32'(pops - p0), 32'd256);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
